// File: rtl/alarm_trigger_pkg.sv
// alarm_trigger_pkg: shared state encodings, time limits and helpers for the
// alarm block. HOUR_MAX/MIN_MAX are also used by the clock counter and the
// display comparator.
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // True when h:m is a legal time of day.
  function automatic logic time_ok(input logic [4:0] h, input logic [5:0] m);
    return (int'(h) <= HOUR_MAX) && (int'(m) <= MIN_MAX);
  endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: time inputs, alarm controls and sounder/display outputs of
// the alarm block.
//   master : drives cur_*, set_*, set_load, alarm_en, stop, snooze; reads outputs
//   slave  : the alarm_trigger side
interface alarm_trigger_if;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       set_load;
  logic       alarm_en;
  logic       stop;
  logic       snooze;
  logic       enc;
  logic       snooze_active;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;

  modport master (
    output cur_hour, cur_min, set_hour, set_min, set_load, alarm_en, stop, snooze,
    input  enc, snooze_active, alm_hour, alm_min
  );

  modport slave (
    input  cur_hour, cur_min, set_hour, set_min, set_load, alarm_en, stop, snooze,
    output enc, snooze_active, alm_hour, alm_min
  );
endinterface

// File: rtl/alarm_trigger_tick_gen.sv
// tick_gen: free-running prescaler producing a 1-cycle tick every CLK_HZ
// clocks (1 Hz at the nominal clock). Shared with the timekeeping block.
//   clk   : system clock
//   rst_n : synchronous active-low reset (counter restarts at 0)
//   tick  : high for one cycle when the counter sits at CLK_HZ-1
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: stores the alarm time, compares it with the running clock and
// runs a ring session (enc high) on the first cycle of a matching minute.
// A session ends on stop, alarm disable or RING_SECS ticks.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alarm_trigger_if.slave (time in, controls, enc/snooze_active,
//                stored alarm time for display)
// Build option: define ALARM_SNOOZE_EN to build the snooze path (SNOOZE state,
// snooze counter). Without it the snooze input is ignored and
// snooze_active is tied low.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alarm_trigger_if.slave  bus
);
  localparam int SW = max2($clog2(max2(RING_SECS, SNOOZE_SECS)), 1);

  state_t        state, state_nx;
  logic [4:0]    alm_hour_q;
  logic [5:0]    alm_min_q;
  logic          match, match_q, trigger, load_ok;
  logic          tick, ring_done;
  logic [SW-1:0] sec_cnt;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  assign load_ok = bus.set_load && time_ok(bus.set_hour, bus.set_min);
  assign match   = (bus.cur_hour == alm_hour_q) && (bus.cur_min == alm_min_q);
  assign trigger = match && !match_q;

  // On a load, match_q takes the comparison against the new alarm time so a
  // load inside an already-matching minute does not produce a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alm_hour_q <= '0;
      alm_min_q  <= '0;
      match_q    <= 1'b1;
    end else if (load_ok) begin
      alm_hour_q <= bus.set_hour;
      alm_min_q  <= bus.set_min;
      match_q    <= (bus.cur_hour == bus.set_hour) && (bus.cur_min == bus.set_min);
    end else begin
      match_q    <= match;
    end
  end

  // Seconds in the current state; restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n)                 sec_cnt <= '0;
    else if (state_nx != state) sec_cnt <= '0;
    else if (state == ST_IDLE)  sec_cnt <= '0;
    else if (tick)              sec_cnt <= sec_cnt + 1'b1;
  end

  assign ring_done = tick && (sec_cnt == SW'(RING_SECS - 1));

`ifdef ALARM_SNOOZE_EN
  localparam int NW = max2($clog2(MAX_SNOOZE + 1), 1);
  logic [NW-1:0] snz_cnt;
  logic          snz_done, snz_ok;

  assign snz_done = tick && (sec_cnt == SW'(SNOOZE_SECS - 1));
  assign snz_ok   = bus.snooze && (snz_cnt < NW'(MAX_SNOOZE));

  always_ff @(posedge clk) begin
    if (!rst_n)
      snz_cnt <= '0;
    else if (state == ST_IDLE && state_nx == ST_RINGING)
      snz_cnt <= '0;
    else if (state == ST_RINGING && state_nx == ST_SNOOZE)
      snz_cnt <= snz_cnt + 1'b1;
  end
`else
  wire        unused_snooze = bus.snooze;
  wire [31:0] unused_cfg    = 32'(MAX_SNOOZE);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (trigger && bus.alarm_en) state_nx = ST_RINGING;
      ST_RINGING:
        if (bus.stop || !bus.alarm_en || ring_done) state_nx = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snz_ok)                            state_nx = ST_SNOOZE;
`endif
      ST_SNOOZE:
`ifdef ALARM_SNOOZE_EN
        if (bus.stop || !bus.alarm_en) state_nx = ST_IDLE;
        else if (snz_done)             state_nx = ST_RINGING;
`else
        state_nx = ST_IDLE;
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded straight from the state register
  always_comb begin
    bus.enc           = (state == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
    bus.snooze_active = (state == ST_SNOOZE);
`else
    bus.snooze_active = 1'b0;
`endif
  end

  assign bus.alm_hour = alm_hour_q;
  assign bus.alm_min  = alm_min_q;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed vectors for alarm_trigger with CLK_HZ=10,
// RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_alarm_trigger;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n;

  alarm_trigger_if bus();

  alarm_trigger #(
    .CLK_HZ(10), .RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int h, input int m);
    bus.cur_hour = 5'(h);
    bus.cur_min  = 6'(m);
  endtask

  task automatic load(input int h, input int m);
    bus.set_hour = 5'(h);
    bus.set_min  = 6'(m);
    bus.set_load = 1'b1;
    cyc(1);
    bus.set_load = 1'b0;
  endtask

  // Leave the alarm minute and come back to it: one trigger.
  task automatic retrigger();
    set_cur(7, 31); cyc(1);
    set_cur(7, 30); cyc(1);
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1'b1; cyc(1); bus.snooze = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.set_hour = '0; bus.set_min = '0; bus.set_load = 1'b0;
    bus.alarm_en = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
    set_cur(7, 29);
    cyc(2);
    chk("rst_enc", bus.enc, 0);
    chk("rst_snz", bus.snooze_active, 0);
    chk("rst_hour", bus.alm_hour, 0);
    chk("rst_min", bus.alm_min, 0);
    rst_n = 1'b1;
    cyc(1);

    // 1: load 07:30, ring on the minute edge, bounded session, no retrigger
    load(7, 30);
    chk("load_hour", bus.alm_hour, 7);
    chk("load_min", bus.alm_min, 30);
    bus.alarm_en = 1'b1;
    cyc(2);
    chk("pre_match_enc", bus.enc, 0);
    set_cur(7, 30);
    chk("same_cycle_enc", bus.enc, 0);
    cyc(1);
    chk("ring_enc", bus.enc, 1);
    n = 0;
    while (bus.enc && n < 100) begin n++; cyc(1); end
    chk("ring_len_ok", int'(n > 30 && n <= 40), 1);
    cyc(30);
    chk("no_retrigger", bus.enc, 0);

    // 2: stop ends session after one edge; new minute rings again
    retrigger();
    chk("ring2_enc", bus.enc, 1);
    pulse_stop();
    chk("stop_enc", bus.enc, 0);
    retrigger();
    chk("ring3_enc", bus.enc, 1);
    pulse_stop();

    // 3: disabled trigger is dropped; disabling mid-ring ends it
    bus.alarm_en = 1'b0;
    retrigger();
    chk("dis_trig_enc", bus.enc, 0);
    bus.alarm_en = 1'b1;
    cyc(5);
    chk("no_deferred", bus.enc, 0);
    retrigger();
    chk("ring4_enc", bus.enc, 1);
    bus.alarm_en = 1'b0;
    cyc(1);
    chk("dis_mid_enc", bus.enc, 0);
    bus.alarm_en = 1'b1;

    // 4: snooze
    retrigger();
    chk("ring5_enc", bus.enc, 1);
    pulse_snooze();
`ifdef ALARM_SNOOZE_EN
    chk("snz1_enc", bus.enc, 0);
    chk("snz1_act", bus.snooze_active, 1);
    n = 0;
    while (bus.snooze_active && n < 100) begin n++; cyc(1); end
    chk("snz1_len_ok", int'(n > 20 && n <= 30), 1);
    chk("snz1_back", bus.enc, 1);
    pulse_snooze();
    chk("snz2_act", bus.snooze_active, 1);
    n = 0;
    while (bus.snooze_active && n < 100) begin n++; cyc(1); end
    chk("snz2_back", bus.enc, 1);
    pulse_snooze();
    chk("snz3_enc", bus.enc, 1);
    chk("snz3_act", bus.snooze_active, 0);
    n = 0;
    while (bus.enc && n < 100) begin n++; cyc(1); end
    chk("snz3_len_ok", int'(n >= 30 && n <= 40), 1);
`else
    chk("nosnz_enc", bus.enc, 1);
    chk("nosnz_act", bus.snooze_active, 0);
    pulse_stop();
`endif
    chk("s4_idle_enc", bus.enc, 0);

    // 5: out-of-range loads ignored; load inside matching minute is silent
    load(24, 0);
    chk("bad_hr_hour", bus.alm_hour, 7);
    chk("bad_hr_min", bus.alm_min, 30);
    load(12, 60);
    chk("bad_min_hour", bus.alm_hour, 7);
    chk("bad_min_min", bus.alm_min, 30);
    load(8, 0);
    chk("load8_hour", bus.alm_hour, 8);
    cyc(2);
    load(7, 30);
    chk("reload_min", bus.alm_min, 30);
    cyc(3);
    chk("load_in_match", bus.enc, 0);

    // 6: reset mid-ring, then timeout/snooze and stop/snooze coincidence
    retrigger();
    chk("ring6_enc", bus.enc, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_enc", bus.enc, 0);
    chk("mid_rst_hour", bus.alm_hour, 0);
    chk("mid_rst_min", bus.alm_min, 0);
    // Reset edge R: prescaler 0. match_q settles to 0 at R+1, trigger at R+2,
    // ticks at R+10/20/30, fourth tick at R+40 ends the session.
    cyc(1);
    set_cur(0, 0);
    cyc(1);
    chk("ring7_enc", bus.enc, 1);
    cyc(37);
    chk("pre_timeout", bus.enc, 1);
    pulse_snooze();
    chk("tmo_snz_enc", bus.enc, 0);
    chk("tmo_snz_act", bus.snooze_active, 0);
    set_cur(0, 1); cyc(1);
    set_cur(0, 0); cyc(1);
    chk("ring8_enc", bus.enc, 1);
    bus.stop = 1'b1; bus.snooze = 1'b1;
    cyc(1);
    bus.stop = 1'b0; bus.snooze = 1'b0;
    chk("stop_snz_enc", bus.enc, 0);
    chk("stop_snz_act", bus.snooze_active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
